// File: rtl/id_ex_pipeline_reg_pkg.sv
// Shared widths, the ID/EX control record and the next-state selector.
// The register bank, the detector and the interface all import this package.
package id_ex_pipeline_reg_pkg;

    localparam int REG_ADDR_WIDTH     = 5;
    localparam int DEF_ALU_OP_WIDTH   = 4;
    localparam int DEF_DATA_WIDTH     = 32;
    localparam int BUBBLE_COUNT_WIDTH = 16;

    // Control bits that can write architectural state; zeroed for bubbles and invalid slots.
    typedef struct packed {
        logic reg_write_enable;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
    } ctrl_t;

    localparam ctrl_t BUBBLE_CTRL = '0;

    typedef enum logic [1:0] {
        SEL_LOAD   = 2'd0,
        SEL_BUBBLE = 2'd1,
        SEL_HOLD   = 2'd2
    } ex_sel_e;

    function automatic logic [BUBBLE_COUNT_WIDTH-1:0] sat_inc(
        input logic [BUBBLE_COUNT_WIDTH-1:0] value
    );
        return (&value) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/id_ex_pipeline_reg_if.sv
// ID-side inputs, EX-side registered outputs and hazard/perf signals of the ID/EX register.
// The pipeline register is the slave; the surrounding core (or a bench) is the master.
interface id_ex_pipeline_reg_if #(
    parameter int DATA_WIDTH   = id_ex_pipeline_reg_pkg::DEF_DATA_WIDTH,
    parameter int ALU_OP_WIDTH = id_ex_pipeline_reg_pkg::DEF_ALU_OP_WIDTH
);
    import id_ex_pipeline_reg_pkg::*;

    logic                          IF_ID_valid;
    logic [REG_ADDR_WIDTH-1:0]     IF_ID_rs;
    logic [REG_ADDR_WIDTH-1:0]     IF_ID_rt;
    logic [REG_ADDR_WIDTH-1:0]     IF_ID_rd;
    logic                          ID_reg_write_enable;
    logic                          ID_mem_read;
    logic                          ID_mem_write;
    logic                          ID_mem_to_reg;
    logic                          ID_alu_src;
    logic [ALU_OP_WIDTH-1:0]       ID_alu_op;
    logic [DATA_WIDTH-1:0]         ID_data_a;
    logic [DATA_WIDTH-1:0]         ID_data_b;
    logic [DATA_WIDTH-1:0]         ID_imm;
    logic [DATA_WIDTH-1:0]         ID_pc;
    logic                          mem_stall;
    logic                          ex_flush;

    logic                          ID_EX_valid;
    logic [REG_ADDR_WIDTH-1:0]     ID_EX_rs;
    logic [REG_ADDR_WIDTH-1:0]     ID_EX_rt;
    logic [REG_ADDR_WIDTH-1:0]     ID_EX_rd;
    logic                          ID_EX_reg_write_enable;
    logic                          ID_EX_mem_read;
    logic                          ID_EX_mem_write;
    logic                          ID_EX_mem_to_reg;
    logic                          ID_EX_alu_src;
    logic [ALU_OP_WIDTH-1:0]       ID_EX_alu_op;
    logic [DATA_WIDTH-1:0]         ID_EX_data_a;
    logic [DATA_WIDTH-1:0]         ID_EX_data_b;
    logic [DATA_WIDTH-1:0]         ID_EX_imm;
    logic [DATA_WIDTH-1:0]         ID_EX_pc;
    logic                          load_use_stall;
    logic [BUBBLE_COUNT_WIDTH-1:0] bubble_count;

    modport master (
        output IF_ID_valid, IF_ID_rs, IF_ID_rt, IF_ID_rd,
               ID_reg_write_enable, ID_mem_read, ID_mem_write, ID_mem_to_reg,
               ID_alu_src, ID_alu_op, ID_data_a, ID_data_b, ID_imm, ID_pc,
               mem_stall, ex_flush,
        input  ID_EX_valid, ID_EX_rs, ID_EX_rt, ID_EX_rd,
               ID_EX_reg_write_enable, ID_EX_mem_read, ID_EX_mem_write, ID_EX_mem_to_reg,
               ID_EX_alu_src, ID_EX_alu_op, ID_EX_data_a, ID_EX_data_b, ID_EX_imm, ID_EX_pc,
               load_use_stall, bubble_count
    );

    modport slave (
        input  IF_ID_valid, IF_ID_rs, IF_ID_rt, IF_ID_rd,
               ID_reg_write_enable, ID_mem_read, ID_mem_write, ID_mem_to_reg,
               ID_alu_src, ID_alu_op, ID_data_a, ID_data_b, ID_imm, ID_pc,
               mem_stall, ex_flush,
        output ID_EX_valid, ID_EX_rs, ID_EX_rt, ID_EX_rd,
               ID_EX_reg_write_enable, ID_EX_mem_read, ID_EX_mem_write, ID_EX_mem_to_reg,
               ID_EX_alu_src, ID_EX_alu_op, ID_EX_data_a, ID_EX_data_b, ID_EX_imm, ID_EX_pc,
               load_use_stall, bubble_count
    );

endinterface

// File: rtl/id_ex_pipeline_reg_load_use_detector.sv
// Combinational load-use hazard check between the load in EX and the instruction in ID.
// r0 is compared like any other index so the result agrees with the forwarding unit.
module load_use_detector
    import id_ex_pipeline_reg_pkg::*;
(
    input  logic                      i_ex_valid,
    input  logic                      i_ex_mem_read,
    input  logic [REG_ADDR_WIDTH-1:0] i_ex_rd,
    input  logic                      i_id_valid,
    input  logic [REG_ADDR_WIDTH-1:0] i_id_rs,
    input  logic [REG_ADDR_WIDTH-1:0] i_id_rt,
    output logic                      o_load_use_stall
);

    logic w_rs_match;
    logic w_rt_match;

    assign w_rs_match       = (i_ex_rd == i_id_rs);
    assign w_rt_match       = (i_ex_rd == i_id_rt);
    assign o_load_use_stall = i_ex_valid & i_ex_mem_read & i_id_valid & (w_rs_match | w_rt_match);

endmodule

// File: rtl/id_ex_pipeline_reg.sv
// ID/EX pipeline register: captures decoded fields, inserts a bubble on flush or
// load-use hazard, freezes on mem_stall and counts inserted bubbles (saturating).
module id_ex_pipeline_reg
    import id_ex_pipeline_reg_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int ALU_OP_WIDTH = DEF_ALU_OP_WIDTH
) (
    input logic                 clk,
    input logic                 rst_n,
    id_ex_pipeline_reg_if.slave bus
);

    logic                          r_valid;
    logic [REG_ADDR_WIDTH-1:0]     r_rs;
    logic [REG_ADDR_WIDTH-1:0]     r_rt;
    logic [REG_ADDR_WIDTH-1:0]     r_rd;
    ctrl_t                         r_ctrl;
    logic                          r_alu_src;
    logic [ALU_OP_WIDTH-1:0]       r_alu_op;
    logic [DATA_WIDTH-1:0]         r_data_a;
    logic [DATA_WIDTH-1:0]         r_data_b;
    logic [DATA_WIDTH-1:0]         r_imm;
    logic [DATA_WIDTH-1:0]         r_pc;
    logic [BUBBLE_COUNT_WIDTH-1:0] r_bubble_count;

    logic    w_load_use_stall;
    ctrl_t   w_id_ctrl;
    ex_sel_e w_sel;

    load_use_detector u_load_use_detector (
        .i_ex_valid       (r_valid),
        .i_ex_mem_read    (r_ctrl.mem_read),
        .i_ex_rd          (r_rd),
        .i_id_valid       (bus.IF_ID_valid),
        .i_id_rs          (bus.IF_ID_rs),
        .i_id_rt          (bus.IF_ID_rt),
        .o_load_use_stall (w_load_use_stall)
    );

    // An empty ID slot still carries its fields but must not write anything.
    assign w_id_ctrl = bus.IF_ID_valid ? ctrl_t'({bus.ID_reg_write_enable, bus.ID_mem_read,
                                                  bus.ID_mem_write, bus.ID_mem_to_reg})
                                       : BUBBLE_CTRL;

    always_comb begin
        w_sel = SEL_LOAD;
        if (bus.mem_stall) begin
            w_sel = SEL_HOLD;
        end else if (bus.ex_flush || w_load_use_stall) begin
            w_sel = SEL_BUBBLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid        <= 1'b0;
            r_rs           <= '0;
            r_rt           <= '0;
            r_rd           <= '0;
            r_ctrl         <= BUBBLE_CTRL;
            r_alu_src      <= 1'b0;
            r_alu_op       <= '0;
            r_data_a       <= '0;
            r_data_b       <= '0;
            r_imm          <= '0;
            r_pc           <= '0;
            r_bubble_count <= '0;
        end else begin
            case (w_sel)
                SEL_BUBBLE: begin
                    r_valid        <= 1'b0;
                    r_rs           <= '0;
                    r_rt           <= '0;
                    r_rd           <= '0;
                    r_ctrl         <= BUBBLE_CTRL;
                    r_alu_src      <= 1'b0;
                    r_alu_op       <= '0;
                    r_data_a       <= '0;
                    r_data_b       <= '0;
                    r_imm          <= '0;
                    r_pc           <= '0;
                    r_bubble_count <= sat_inc(r_bubble_count);
                end
                SEL_LOAD: begin
                    r_valid   <= bus.IF_ID_valid;
                    r_rs      <= bus.IF_ID_rs;
                    r_rt      <= bus.IF_ID_rt;
                    r_rd      <= bus.IF_ID_rd;
                    r_ctrl    <= w_id_ctrl;
                    r_alu_src <= bus.ID_alu_src;
                    r_alu_op  <= bus.ID_alu_op;
                    r_data_a  <= bus.ID_data_a;
                    r_data_b  <= bus.ID_data_b;
                    r_imm     <= bus.ID_imm;
                    r_pc      <= bus.ID_pc;
                end
                default: begin
                    r_valid <= r_valid;
                end
            endcase
        end
    end

    assign bus.ID_EX_valid            = r_valid;
    assign bus.ID_EX_rs               = r_rs;
    assign bus.ID_EX_rt               = r_rt;
    assign bus.ID_EX_rd               = r_rd;
    assign bus.ID_EX_reg_write_enable = r_ctrl.reg_write_enable;
    assign bus.ID_EX_mem_read         = r_ctrl.mem_read;
    assign bus.ID_EX_mem_write        = r_ctrl.mem_write;
    assign bus.ID_EX_mem_to_reg       = r_ctrl.mem_to_reg;
    assign bus.ID_EX_alu_src          = r_alu_src;
    assign bus.ID_EX_alu_op           = r_alu_op;
    assign bus.ID_EX_data_a           = r_data_a;
    assign bus.ID_EX_data_b           = r_data_b;
    assign bus.ID_EX_imm              = r_imm;
    assign bus.ID_EX_pc               = r_pc;
    assign bus.load_use_stall         = w_load_use_stall;
    assign bus.bubble_count           = r_bubble_count;

endmodule
